add_fu_pipe: RTL and testbench
==============================

# add_fu_pipe

Parametrised, pipelined integer add/subtract functional unit for the Tomasulo ADD reservation-station path. It takes tagged operand pairs from the issuing reservation station over a valid/ready handshake and computes A+B+Cin or A−B at any width. The result passes through a configurable number of elastic register stages. Results, with carry-out, signed overflow and the originating tag, are presented to the common data bus (CDB) arbiter over a second valid/ready handshake; a synchronous flush discards all in-flight work.

## Interface
- WIDTH, 32, operand/result width (≥2)
- STAGES, 2, pipeline register stages (≥1); equals unstalled latency in cycles
- TAG_W, 4, reservation-station tag width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; kills every in-flight op
- in_valid  in  1  operand pair offered
- in_ready  out  1  unit can accept this cycle
- in_op  in  1  0 = add, 1 = subtract
- in_a, in_b  in  WIDTH  operands
- in_cin  in  1  carry-in (add only)
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result offered to CDB
- out_ready  in  1  CDB grant
- out_sum  out  WIDTH  result
- out_cout  out  1  carry-out of the WIDTH-bit sum
- out_ovf  out  1  two's-complement overflow
- out_tag  out  TAG_W  tag of the result
- busy  out  1  OR of all stage valid bits

## Operation
- Add computes {cout,sum} = a + b + cin (WIDTH+1-bit, unsigned).
- Subtract computes {cout,sum} = a + ~b + 1, with in_cin ignored. cout=1 means no borrow.
- ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' = b for add and ~b for subtract.
- The adder is combinational in front of stage 1. Stages 2..STAGES only carry {valid, sum, cout, ovf, tag}.
- Each stage holds one op. Stage i loads when it is empty or when stage i+1 loads. The last stage loads when it is empty or out_ready=1.
- in_ready = (stage 1 can load) && !flush. This is combinational through out_ready when all stages are full.
- Accept occurs when in_valid && in_ready at the rising edge.
- Outputs are driven directly from the last stage register.
- While out_valid=1 && out_ready=0, all out_* stay stable and the ops are held.
- flush=1 clears every valid bit at the next edge and blocks acceptance in that cycle. An out_valid/out_ready handshake in the flush cycle still completes.
- rst clears every valid bit and all data registers to 0 immediately, without waiting for a clock edge.
- Reset values: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_tag=0, busy=0. in_ready becomes 1 once rst is low.

## Timing
- An op accepted in cycle 0 shows out_valid=1 in cycle STAGES when no stall occurs.
- Throughput is 1 op/cycle with out_ready held high. Order is strictly FIFO.
- Capacity is STAGES ops. When all stages are full and out_ready=0, in_ready=0.
- When full and out_ready=1, a new op is accepted in the same cycle the oldest drains (no bubble).
- Bubbles collapse: an empty stage loads even if downstream is stalled.
- Arithmetic wraps modulo 2^WIDTH; overflow is flagged only, never saturated.
- Asserting rst mid-stall or mid-flush: the reset wins and all ops are lost.
- Deasserting rst: the first accept can happen at the first rising edge after deassertion.

## Test plan
- Add, STAGES=2, WIDTH=32: a=0x00000009, b=0xFFFFFFFC, cin=0, tag=3 → in cycle 2, out_sum=0x00000005, cout=1, ovf=0, tag=3.
- Sub and overflow:
  - a=5, b=7, op=1 → sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x7FFFFFFF, b=1, op=0 → sum=0x80000000, cout=0, ovf=1.
  - a=0x80000000, b=1, op=1 → sum=0x7FFFFFFF, ovf=1.
- Streaming: 4 back-to-back ops (tags 1..4) with out_ready=1 → out_valid high in cycles 2..5 with tags 1,2,3,4 and no gaps.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 →
  - exactly 2 ops accepted, then in_ready=0;
  - out_* stable throughout the stall;
  - on release, tags emerge in order and in_ready returns the same cycle.
- Flush: 2 ops in flight, flush=1 with in_valid=1 → that input is not accepted, busy=0 next cycle, and no out_valid follows for the flushed tags.
- Async reset: assert rst between clock edges with 2 ops in flight → out_valid and busy drop to 0 before the next edge, and out_sum=0.

Source files
------------

// File: rtl/add_fu_pipe.sv
// Pipelined add/subtract functional unit for the ADD reservation-station path.
// The adder sits in front of the first stage; later stages form an elastic FIFO-ordered pipe.
module add_fu_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef struct packed {
    logic             ovf;
    logic             cout;
    logic [WIDTH-1:0] sum;
  } res_t;

  // Subtract is a + ~b + 1, so the forced carry-in doubles as the subtract select.
  function automatic res_t add_fn(input logic op, input logic signed [WIDTH-1:0] a,
                                  input logic signed [WIDTH-1:0] b, input logic cin);
    logic signed [WIDTH-1:0] bx;
    logic [WIDTH:0]          full;
    res_t                    r;
    bx     = op ? ~b : b;
    full   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, (op | cin)};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == bx[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  res_t              res_p0;
  logic              accept;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] vld_p;
  res_t              res_p [STAGES];
  logic [TAG_W-1:0]  tag_p [STAGES];

  assign res_p0 = add_fn(in_op, in_a, in_b, in_cin);

  // A stage can load if any stage at or after it is empty, or the CDB takes the head.
  always_comb begin
    logic chain;
    chain = out_ready;
    load  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain   = chain || !vld_p[i];
      load[i] = chain;
    end
  end

  assign in_ready = load[0] && !flush;
  assign accept   = in_valid && in_ready;

  // Stage 1 captures the adder result; stages 2..STAGES shift when they may load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_p[i] <= '0;
        tag_p[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        vld_p[0] <= accept;
        res_p[0] <= res_p0;
        tag_p[0] <= in_tag;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          vld_p[i] <= vld_p[i-1];
          res_p[i] <= res_p[i-1];
          tag_p[i] <= tag_p[i-1];
        end
      end
      if (flush) vld_p <= '0;
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign out_sum   = res_p[STAGES-1].sum;
  assign out_cout  = res_p[STAGES-1].cout;
  assign out_ovf   = res_p[STAGES-1].ovf;
  assign out_tag   = tag_p[STAGES-1];
  assign busy      = |vld_p;

endmodule

// File: tb/tb_add_fu_pipe.sv
// Self-checking bench for add_fu_pipe: directed steps plus randomized traffic
// checked against a queue-based arithmetic reference model.
module tb_add_fu_pipe;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  add_fu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   last_acc;

  // Plain-integer arithmetic: the unsigned result gives sum/carry, the signed result gives overflow.
  function automatic res_t ref_model(input logic op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic cin,
                                     input logic [TAG_W-1:0] tag);
    res_t   r;
    longint ua, ub, sa, sb, u, s, maxv, minv;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    maxv = (longint'(1) <<< (WIDTH - 1)) - 1;
    minv = -(longint'(1) <<< (WIDTH - 1));
    if (op) begin
      u      = ua - ub;
      s      = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      u      = ua + ub + longint'(cin);
      s      = sa + sb + longint'(cin);
      r.cout = (u >= (longint'(1) <<< WIDTH));
    end
    r.sum = u[WIDTH-1:0];
    r.ovf = (s > maxv) || (s < minv);
    r.tag = tag;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock cycle: called at posedge+1 with inputs already driven.
  task automatic step();
    bit   drn;
    res_t nr, ex;
    #3;
    check("in_ready", 64'(in_ready), 64'(!flush && ((q.size() < STAGES) || out_ready)));
    if (q.size() == 0) check("idle_valid", 64'(out_valid), 64'(0));
    drn      = out_valid && out_ready;
    last_acc = in_valid && in_ready;
    nr       = ref_model(in_op, in_a, in_b, in_cin, in_tag);
    if (drn && q.size() > 0) begin
      ex = q.pop_front();
      check("sum",  64'(out_sum),  64'(ex.sum));
      check("cout", 64'(out_cout), 64'(ex.cout));
      check("ovf",  64'(out_ovf),  64'(ex.ovf));
      check("tag",  64'(out_tag),  64'(ex.tag));
    end
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else if (last_acc) q.push_back(nr);
    check("busy", 64'(busy), 64'(q.size() != 0));
  endtask

  task automatic drive(input logic v, input logic op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic cin, input logic [TAG_W-1:0] tag);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_cin = cin; in_tag = tag;
  endtask

  typedef struct packed {
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t             vecs [4];
  logic [WIDTH-1:0] held_sum;
  logic [TAG_W-1:0] held_tag;
  int               accepts;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0009, 32'hFFFF_FFFC, 1'b0, 4'd3, 32'h0000_0005, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 4'd6, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'd7, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 4'd9, 32'h7FFF_FFFF, 1'b1, 1'b1};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #7;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_sum",   64'(out_sum),   64'(0));
    check("rst_out_cout",  64'(out_cout),  64'(0));
    check("rst_out_ovf",   64'(out_ovf),   64'(0));
    check("rst_out_tag",   64'(out_tag),   64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Single isolated ops: result appears exactly STAGES cycles after accept.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].cin, vecs[k].tag);
      step();
      check("lat_accept", 64'(last_acc), 64'(1));
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
      check("lat_cycle1_valid", 64'(out_valid), 64'(0));
      step();
      check("lat_valid", 64'(out_valid), 64'(1));
      check("vec_sum",   64'(out_sum),   64'(vecs[k].sum));
      check("vec_cout",  64'(out_cout),  64'(vecs[k].cout));
      check("vec_ovf",   64'(out_ovf),   64'(vecs[k].ovf));
      check("vec_tag",   64'(out_tag),   64'(vecs[k].tag));
      step();
    end

    // Streaming: tags 1..4 back to back, results in cycles 2..5 with no gaps.
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive(1'b1, 1'($urandom_range(1)), $urandom, $urandom, 1'($urandom_range(1)), 4'(c + 1));
      else       drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
      step();
      check("stream_valid", 64'(out_valid), 64'((c + 1 >= 2) && (c + 1 <= 5)));
      if ((c + 1 >= 2) && (c + 1 <= 5)) check("stream_tag", 64'(out_tag), 64'(c));
    end

    // Backpressure: 4 stalled cycles with input offered; capacity fills then holds.
    out_ready = 1'b0;
    accepts   = 0;
    held_sum  = '0;
    held_tag  = '0;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 1'($urandom_range(1)), $urandom, $urandom, 1'($urandom_range(1)), 4'(5 + j));
      step();
      if (last_acc) accepts++;
      if (j == 1) begin
        held_sum = out_sum;
        held_tag = out_tag;
      end
      if (j > 1) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_sum",   64'(out_sum),   64'(held_sum));
        check("stall_tag",   64'(out_tag),   64'(held_tag));
      end
    end
    check("stall_accepts", 64'(accepts), 64'(2));
    check("stall_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(in_ready), 64'(1));
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    for (int j = 0; j < 4; j++) step();
    check("stall_drained", 64'(q.size()), 64'(0));

    // Flush with two ops in flight and a new op offered.
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, 1'b0, $urandom, $urandom, 1'b0, 4'(10 + j));
      step();
    end
    drive(1'b1, 1'b0, $urandom, $urandom, 1'b0, 4'd12);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'(0));
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    check("flush_busy", 64'(busy), 64'(0));
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      check("flush_no_valid", 64'(out_valid), 64'(0));
    end

    // Asynchronous reset between edges with two ops in flight.
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, 1'b0, 32'h1234_5678 + 32'(j), 32'h1111_1111, 1'b1, 4'(13 + j));
      step();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_busy",  64'(busy),      64'(0));
    check("arst_sum",   64'(out_sum),   64'(0));
    q.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic with occasional flushes and corner operands.
    for (int n = 0; n < 400; n++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = (($urandom_range(3) == 0) ? {1'b0, {(WIDTH-1){1'b1}}} : WIDTH'($urandom));
      rb = (($urandom_range(3) == 0) ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'($urandom));
      drive(1'($urandom_range(3) != 0), 1'($urandom_range(1)), ra, rb,
            1'($urandom_range(1)), TAG_W'($urandom));
      out_ready = 1'($urandom_range(2) != 0);
      flush     = ($urandom_range(31) == 0);
      step();
    end
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    for (int n = 0; n < 20 && q.size() > 0; n++) step();
    check("final_drain", 64'(q.size()), 64'(0));
    check("final_busy", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
